// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - UART transmit serialiser: start, LSB-first data, optional parity, stop
module uart_transmitter #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Tx_EN,
    input  logic                  Tx_WR,
    input  logic [DATA_WIDTH-1:0] Tx_DATA,
    input  logic                  Tx_sample_ENABLE,
    output logic                  TxD,
    output logic                  Tx_BUSY
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_WIDTH - 1);
    localparam logic          ODD       = (PARITY_ODD != 0);
    localparam logic          HAS_PAR   = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                  state_q, state_d;
    logic [TW-1:0]           tick_q, tick_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
    logic                    parity_q, parity_d;
    logic                    txd_q, txd_d;
    logic                    busy_q, busy_d;
    logic                    bit_end;

    assign bit_end = Tx_sample_ENABLE && (tick_q == TICK_LAST);

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        idx_d    = idx_q;
        shreg_d  = shreg_q;
        parity_d = parity_q;

        if (!Tx_EN) begin
            state_d = S_IDLE;
            tick_d  = '0;
            idx_d   = '0;
        end else if (state_q == S_IDLE) begin
            // Busy is exactly "not idle", so the idle check covers !Tx_BUSY.
            if (Tx_WR) begin
                shreg_d  = Tx_DATA;
                parity_d = (^Tx_DATA) ^ ODD;
                tick_d   = '0;
                idx_d    = '0;
                state_d  = S_START;
            end
        end else if (Tx_sample_ENABLE) begin
            tick_d = bit_end ? '0 : tick_q + 1'b1;
            if (bit_end) begin
                case (state_q)
                    S_START: begin
                        state_d = S_DATA;
                        idx_d   = '0;
                    end
                    S_DATA: begin
                        shreg_d = shreg_q >> 1;
                        if (idx_q == IDX_LAST) begin
                            state_d = HAS_PAR ? S_PARITY : S_STOP;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                    S_PARITY: state_d = S_STOP;
                    S_STOP:   state_d = S_IDLE;
                    default:  state_d = S_IDLE;
                endcase
            end
        end

        // Line level follows the next state so TxD comes straight from a flop.
        case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shreg_d[0];
            S_PARITY: txd_d = parity_d;
            default:  txd_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            tick_q   <= '0;
            idx_q    <= '0;
            shreg_q  <= '0;
            parity_q <= 1'b0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            idx_q    <= idx_d;
            shreg_q  <= shreg_d;
            parity_q <= parity_d;
            txd_q    <= txd_d;
            busy_q   <= busy_d;
        end
    end

    assign TxD     = txd_q;
    assign Tx_BUSY = busy_q;

endmodule
